// File: rtl/ring_osc_cal_pkg.sv
// Shared types, constants and the code-to-trim thermometer mapping for the
// ring oscillator trim calibration controller.
package ring_osc_cal_pkg;

  localparam int NUM_STAGES = 13;
  localparam int MAX_CODE   = 2 * NUM_STAGES;
  localparam int TRIM_W     = 2 * NUM_STAGES;
  localparam int CODE_W     = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OSCRST,
    ST_SETTLE,
    ST_MEASURE,
    ST_COMPARE,
    ST_LOCKED,
    ST_FAIL
  } cal_state_e;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN
  } step_dir_e;

  // Primary stages fill first; secondary stages only once all primaries are on.
  function automatic logic [TRIM_W-1:0] code_to_trim(input logic [CODE_W-1:0] code);
    logic [NUM_STAGES-1:0] pri;
    logic [NUM_STAGES-1:0] sec;
    pri = '0;
    sec = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      pri[i] = (int'(code) > i);
      sec[i] = (int'(code) > NUM_STAGES + i);
    end
    return {sec, pri};
  endfunction

endpackage

// File: rtl/ring_osc_edge_counter.sv
// Synchronizes the oscillator-domain toggle and counts both of its edges
// into a saturating counter with synchronous clear and enable.
module ring_osc_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             osc_tick,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic sync_q1;
  logic sync_q2;
  logic sync_q3;
  logic edge_seen;

  // sync_q3 only delays the already-synchronized level for edge detection.
  assign edge_seen = sync_q2 ^ sync_q3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      sync_q3 <= 1'b0;
      count   <= '0;
    end else begin
      sync_q1 <= osc_tick;
      sync_q2 <= sync_q1;
      sync_q3 <= sync_q2;
      if (clr) begin
        count <= '0;
      end else if (en && edge_seen && (count != '1)) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ring_osc_trim_cal.sv
// Closed-loop trim search for the 13-stage ring oscillator: measure edges per
// window, step the thermometer code until the count lands inside target +/- tol.
module ring_osc_trim_cal
  import ring_osc_cal_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int WIN_CYC    = 1024,
  parameter int SETTLE_CYC = 16,
  parameter int RST_CYC    = 4,
  parameter int MAX_ITER   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              manual,
  input  logic [CODE_W-1:0] manual_code,
  input  logic [CNT_W-1:0]  target_cnt,
  input  logic [7:0]        tol,
  input  logic              osc_tick,
  output logic              osc_reset,
  output logic [TRIM_W-1:0] trim,
  output logic [CODE_W-1:0] trim_code,
  output logic [CNT_W-1:0]  meas_cnt,
  output logic              busy,
  output logic              locked,
  output logic              approx,
  output logic              fail
);

  localparam int EW      = CNT_W + 1;
  localparam int TMR_MAX = (WIN_CYC > SETTLE_CYC)
                         ? ((WIN_CYC > RST_CYC) ? WIN_CYC : RST_CYC)
                         : ((SETTLE_CYC > RST_CYC) ? SETTLE_CYC : RST_CYC);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int ITER_W  = $clog2(MAX_ITER + 1);

  cal_state_e        state;
  step_dir_e         last_dir;
  logic [TMR_W-1:0]  phase_cnt;
  logic [ITER_W-1:0] iter_cnt;
  logic [CNT_W-1:0]  win_cnt;

  logic [EW-1:0]     cnt_ext, tgt_ext, tol_ext, hi_lim, lo_lim;
  logic              too_fast, too_slow, at_end;
  logic [CODE_W-1:0] step_code, man_code;

  ring_osc_edge_counter #(.CNT_W(CNT_W)) u_edge_cnt (
    .clk      (clk),
    .reset    (reset),
    .osc_tick (osc_tick),
    .clr      (state == ST_SETTLE),
    .en       (state == ST_MEASURE),
    .count    (win_cnt)
  );

  // One extra bit keeps target+tol from wrapping; target-tol floors at zero.
  assign cnt_ext  = {1'b0, win_cnt};
  assign tgt_ext  = {1'b0, target_cnt};
  assign tol_ext  = EW'(tol);
  assign hi_lim   = tgt_ext + tol_ext;
  assign lo_lim   = (tgt_ext > tol_ext) ? (tgt_ext - tol_ext) : '0;
  assign too_fast = (cnt_ext > hi_lim);
  assign too_slow = (cnt_ext < lo_lim);

  assign at_end    = too_fast ? (trim_code == CODE_W'(MAX_CODE)) : (trim_code == '0);
  assign step_code = too_fast ? (trim_code + CODE_W'(1)) : (trim_code - CODE_W'(1));
  assign man_code  = (manual_code > CODE_W'(MAX_CODE)) ? CODE_W'(MAX_CODE) : manual_code;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      last_dir  <= DIR_NONE;
      phase_cnt <= '0;
      iter_cnt  <= '0;
      osc_reset <= 1'b1;
      trim      <= '0;
      trim_code <= '0;
      meas_cnt  <= '0;
      busy      <= 1'b0;
      locked    <= 1'b0;
      approx    <= 1'b0;
      fail      <= 1'b0;
    end else if (manual) begin
      // NOTE: every register here uses <= so all of them update from the same
      // pre-edge values; a blocking = would leak new values into later reads.
      state     <= ST_IDLE;
      osc_reset <= 1'b0;
      busy      <= 1'b0;
      locked    <= 1'b0;
      approx    <= 1'b0;
      fail      <= 1'b0;
      trim_code <= man_code;
      trim      <= code_to_trim(man_code);
    end else begin
      unique case (state)
        ST_IDLE, ST_LOCKED, ST_FAIL: begin
          osc_reset <= 1'b0;
          if (start) begin
            state     <= ST_OSCRST;
            osc_reset <= 1'b1;
            busy      <= 1'b1;
            locked    <= 1'b0;
            approx    <= 1'b0;
            fail      <= 1'b0;
            trim_code <= '0;
            trim      <= '0;
            iter_cnt  <= '0;
            last_dir  <= DIR_NONE;
            phase_cnt <= '0;
          end
        end
        ST_OSCRST: begin
          if (phase_cnt == TMR_W'(RST_CYC - 1)) begin
            phase_cnt <= '0;
            osc_reset <= 1'b0;
            state     <= ST_SETTLE;
          end else begin
            phase_cnt <= phase_cnt + TMR_W'(1);
          end
        end
        ST_SETTLE: begin
          if (phase_cnt == TMR_W'(SETTLE_CYC - 1)) begin
            phase_cnt <= '0;
            state     <= ST_MEASURE;
          end else begin
            phase_cnt <= phase_cnt + TMR_W'(1);
          end
        end
        ST_MEASURE: begin
          if (phase_cnt == TMR_W'(WIN_CYC - 1)) begin
            phase_cnt <= '0;
            state     <= ST_COMPARE;
          end else begin
            phase_cnt <= phase_cnt + TMR_W'(1);
          end
        end
        ST_COMPARE: begin
          meas_cnt <= win_cnt;
          iter_cnt <= iter_cnt + ITER_W'(1);
          if (!too_fast && !too_slow) begin
            state  <= ST_LOCKED;
            busy   <= 1'b0;
            locked <= 1'b1;
          end else if (at_end) begin
            state <= ST_FAIL;
            busy  <= 1'b0;
            fail  <= 1'b1;
          end else if (last_dir == (too_fast ? DIR_DOWN : DIR_UP)) begin
            // Oscillating around the target: keep the code just measured.
            state  <= ST_LOCKED;
            busy   <= 1'b0;
            locked <= 1'b1;
            approx <= 1'b1;
          end else if (iter_cnt == ITER_W'(MAX_ITER - 1)) begin
            state <= ST_FAIL;
            busy  <= 1'b0;
            fail  <= 1'b1;
          end else begin
            state     <= ST_SETTLE;
            trim_code <= step_code;
            trim      <= code_to_trim(step_code);
            last_dir  <= too_fast ? DIR_UP : DIR_DOWN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_osc_trim_cal.sv
// Directed bench for ring_osc_trim_cal: an oscillator whose period follows the
// trim, plus a timeline model of the calibration search checked every cycle.
module tb_ring_osc_trim_cal;

  localparam int CNT_W      = 16;
  localparam int WIN_CYC    = 1024;
  localparam int SETTLE_CYC = 16;
  localparam int RST_CYC    = 4;
  localparam int MAX_ITER   = 32;
  localparam int ITER_LEN   = SETTLE_CYC + WIN_CYC + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             manual;
  logic [4:0]       manual_code;
  logic [CNT_W-1:0] target_cnt;
  logic [7:0]       tol;
  logic             osc_tick = 1'b0;
  logic             osc_reset;
  logic [25:0]      trim;
  logic [4:0]       trim_code;
  logic [CNT_W-1:0] meas_cnt;
  logic             busy, locked, approx, fail;

  ring_osc_trim_cal dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .manual      (manual),
    .manual_code (manual_code),
    .target_cnt  (target_cnt),
    .tol         (tol),
    .osc_tick    (osc_tick),
    .osc_reset   (osc_reset),
    .trim        (trim),
    .trim_code   (trim_code),
    .meas_cnt    (meas_cnt),
    .busy        (busy),
    .locked      (locked),
    .approx      (approx),
    .fail        (fail)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  // Oscillator: toggles every 20+4*code cycles, frozen while held in reset.
  int toggles = 0;
  int div_cnt = 0;
  always begin
    @(posedge clk);
    #2;
    if (reset || osc_reset) begin
      div_cnt = 0;
    end else begin
      div_cnt++;
      if (div_cnt >= 20 + 4 * $countones(trim)) begin
        div_cnt  = 0;
        osc_tick = ~osc_tick;
        toggles++;
      end
    end
  end

  // Expected outputs; a code of k always means the lowest k trim bits are set.
  bit       chk_en = 1'b0;
  bit       exp_osc_reset, exp_busy, exp_locked, exp_approx, exp_fail;
  int       exp_code;

  function automatic logic [25:0] model_trim(input int code);
    logic [26:0] w;
    w = 27'(1) << code;
    return 26'(w - 27'(1));
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("trim",      trim,      model_trim(exp_code));
      check("trim_code", trim_code, exp_code);
      check("osc_reset", osc_reset, exp_osc_reset);
      check("busy",      busy,      exp_busy);
      check("locked",    locked,    exp_locked);
      check("approx",    approx,    exp_approx);
      check("fail",      fail,      exp_fail);
    end
  end

  task automatic set_reset_expect();
    exp_osc_reset = 1'b1;
    exp_busy      = 1'b0;
    exp_locked    = 1'b0;
    exp_approx    = 1'b0;
    exp_fail      = 1'b0;
    exp_code      = 0;
  endtask

  // rel counts clock edges since the start pulse was taken.
  int rel      = 0;
  int stop_rel = -1;

  task automatic adv(input int upto, output bit stopped);
    stopped = 1'b0;
    while (rel < upto) begin
      if (rel == stop_rel) begin
        stopped = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
      rel++;
    end
  endtask

  // Walks the search one iteration at a time; returns early at stop_at.
  task automatic run_cal(input int tgt, input int tl, input int stop_at, output int iters);
    int base, snap, cnt, lo, hi, prev, dir, code;
    bit stopped, done;
    target_cnt = CNT_W'(tgt);
    tol        = 8'(tl);
    stop_rel   = stop_at;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    rel   = 0;
    code  = 0;
    prev  = 0;
    iters = 0;
    exp_code = 0; exp_busy = 1'b1; exp_osc_reset = 1'b1;
    exp_locked = 1'b0; exp_approx = 1'b0; exp_fail = 1'b0;
    adv(RST_CYC, stopped);
    if (stopped) return;
    exp_osc_reset = 1'b0;
    base = RST_CYC;
    done = 1'b0;
    lo = (tgt > tl) ? tgt - tl : 0;
    hi = tgt + tl;
    while (!done) begin
      // A toggle lands in the count three edges later (2-FF sync + edge detect).
      adv(base + SETTLE_CYC - 2, stopped);
      if (stopped) return;
      snap = toggles;
      adv(base + SETTLE_CYC + WIN_CYC - 2, stopped);
      if (stopped) return;
      cnt = toggles - snap;
      adv(base + ITER_LEN, stopped);
      if (stopped) return;
      iters++;
      check_range("meas_cnt", int'(meas_cnt), cnt - 1, cnt + 1);
      if (cnt >= lo && cnt <= hi) begin
        exp_busy = 1'b0; exp_locked = 1'b1; done = 1'b1;
      end else begin
        dir = (cnt > hi) ? 1 : -1;
        if ((dir == 1 && code == 26) || (dir == -1 && code == 0)) begin
          exp_busy = 1'b0; exp_fail = 1'b1; done = 1'b1;
        end else if (prev == -dir) begin
          exp_busy = 1'b0; exp_locked = 1'b1; exp_approx = 1'b1; done = 1'b1;
        end else if (iters == MAX_ITER) begin
          exp_busy = 1'b0; exp_fail = 1'b1; done = 1'b1;
        end else begin
          code += dir;
          prev = dir;
          exp_code = code;
          base += ITER_LEN;
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int iters;
    reset = 1'b1; start = 1'b0; manual = 1'b0; manual_code = '0;
    target_cnt = '0; tol = '0;
    set_reset_expect();
    chk_en = 1'b1;

    repeat (3) @(negedge clk);
    check("reset osc_reset", osc_reset, 1);
    check("reset trim", trim, 26'h0);
    check("reset meas_cnt", meas_cnt, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    exp_osc_reset = 1'b0;
    @(negedge clk);
    check("idle osc_reset", osc_reset, 0);

    // Lock: 0,1,2,3 visited, lock at 3 after 4 iterations.
    run_cal(32, 2, -1, iters);
    @(negedge clk);
    check("lock iters", iters, 4);
    check("lock latency", rel, RST_CYC + 4 * ITER_LEN);
    check("lock locked", locked, 1);
    check("lock approx", approx, 0);
    check("lock code", trim_code, 3);
    check("lock trim", trim, 26'h0000007);
    check("lock busy", busy, 0);

    // Fail fast: runs off the top.
    run_cal(5, 0, -1, iters);
    @(negedge clk);
    check("ffast iters", iters, 27);
    check("ffast fail", fail, 1);
    check("ffast code", trim_code, 26);
    check("ffast trim", trim, 26'h3FFFFFF);
    check_range("ffast meas", int'(meas_cnt), 8, 9);

    // Fail slow: already too slow at code 0.
    run_cal(60, 2, -1, iters);
    @(negedge clk);
    check("fslow iters", iters, 1);
    check("fslow fail", fail, 1);
    check("fslow code", trim_code, 0);
    check_range("fslow meas", int'(meas_cnt), 51, 52);

    // Reversal: overshoot at 3, lock there with approx.
    run_cal(34, 0, -1, iters);
    @(negedge clk);
    check("rev iters", iters, 4);
    check("rev locked", locked, 1);
    check("rev approx", approx, 1);
    check("rev code", trim_code, 3);

    // Start while busy is ignored, then manual override mid-MEASURE.
    run_cal(32, 2, RST_CYC + ITER_LEN + 5, iters);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (200) @(negedge clk);
    check("busy start code", trim_code, 1);
    check("busy start busy", busy, 1);
    manual = 1'b1;
    manual_code = 5'd15;
    @(posedge clk);
    #1;
    exp_busy = 1'b0; exp_code = 15;
    @(negedge clk);
    check("manual busy", busy, 0);
    check("manual trim", trim, 26'h0007FFF);
    manual_code = 5'd30;
    @(posedge clk);
    #1;
    exp_code = 26;
    @(negedge clk);
    check("manual clamp", trim_code, 26);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("manual start busy", busy, 0);
    manual = 1'b0;
    repeat (20) @(negedge clk);
    check("manual release code", trim_code, 26);
    check("manual release busy", busy, 0);

    // Reset mid-MEASURE at code 2, then a fresh lock.
    run_cal(32, 2, RST_CYC + 2 * ITER_LEN + SETTLE_CYC + 200, iters);
    @(negedge clk);
    check("pre-reset code", trim_code, 2);
    #2;
    reset = 1'b1;
    set_reset_expect();
    repeat (3) @(negedge clk);
    check("mid reset trim", trim, 26'h0);
    check("mid reset osc_reset", osc_reset, 1);
    check("mid reset busy", busy, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    exp_osc_reset = 1'b0;
    @(negedge clk);
    check("post reset osc_reset", osc_reset, 0);
    run_cal(32, 2, -1, iters);
    @(negedge clk);
    check("relock iters", iters, 4);
    check("relock locked", locked, 1);
    check("relock code", trim_code, 3);
    check("relock trim", trim, 26'h0000007);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
